// File: rtl/int_add_arbiter_if.sv
// Request/response bundle for the shared integer adder: per-requester operand
// lanes with one-hot grant, plus a single tagged valid/ready result port.
interface int_add_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_ovf;
  logic                          busy;

  // The arbiter owns grants and the response; requesters/consumer own the rest.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );
endinterface

// File: rtl/int_add_arbiter.sv
// Round-robin front end for one shared signed adder. One request in flight:
// grant in IDLE, add in ADD, hold the tagged result in RESP until consumed.
module int_add_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input  logic             clk,
  input  logic             rst,
  int_add_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic                  rsp_ovf_q, rsp_ovf_d;

  logic                  found_s;
  logic [ID_W-1:0]       win_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [DATA_WIDTH-1:0] sel_a_s;
  logic [DATA_WIDTH-1:0] sel_b_s;
  logic [DATA_WIDTH-1:0] sum_s;

  function automatic logic add_ovf(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic [DATA_WIDTH-1:0] s);
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  // Round-robin scan: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] cand;
    found_s = 1'b0;
    win_s   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = {1'b0, ptr_q} + (ID_W+1)'(k);
      cand    = (cand >= (ID_W+1)'(NUM_REQ)) ? cand - (ID_W+1)'(NUM_REQ) : cand;
      win_s   = (!found_s && bus.req_valid[cand[ID_W-1:0]]) ? cand[ID_W-1:0] : win_s;
      found_s = found_s | bus.req_valid[cand[ID_W-1:0]];
    end
  end

  assign grant_s = found_s ? (NUM_REQ'(1'b1) << win_s) : '0;

  // Operand mux for the winning lane.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = (win_s == ID_W'(i)) ? bus.req_a[i*DATA_WIDTH +: DATA_WIDTH] : sel_a_s;
      sel_b_s = (win_s == ID_W'(i)) ? bus.req_b[i*DATA_WIDTH +: DATA_WIDTH] : sel_b_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (found_s) state_d = ADD;
        else         state_d = IDLE;
      end
      ADD:  state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
        else               state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the grant is suppressed while reset is held.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (!rst) bus.req_ready = grant_s;
        else      bus.req_ready = '0;
      end
      ADD:  bus.rsp_valid = 1'b0;
      RESP: bus.rsp_valid = 1'b1;
      default: begin
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
      end
    endcase
  end

  // The adder sees only the latched operands, never the live request lanes.
  assign sum_s = op_a_q + op_b_q;

  // Datapath next values: latch on grant, compute in ADD, hold otherwise.
  always_comb begin
    ptr_d      = ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_ovf_d  = rsp_ovf_q;
    if ((state_q == IDLE) && found_s) begin
      op_a_d = sel_a_s;
      op_b_d = sel_b_s;
      id_d   = win_s;
      ptr_d  = (win_s == ID_W'(NUM_REQ-1)) ? '0 : win_s + ID_W'(1);
    end else if (state_q == ADD) begin
      rsp_data_d = sum_s;
      rsp_ovf_d  = add_ovf(op_a_q, op_b_q, sum_s);
      rsp_id_d   = id_q;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id   = rsp_id_q;
  assign bus.rsp_ovf  = rsp_ovf_q;
endmodule

// File: tb/tb_int_add_arbiter.sv
// Self-checking bench: transaction-level model (pointer, in-flight op, age)
// compared every cycle, directed scenarios with literal results, random traffic.
module tb_int_add_arbiter;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_add_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(N)) bus ();
  int_add_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  function automatic longint wide_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return longint'($signed(a)) + longint'($signed(b));
  endfunction

  // ---------------- behavioural model ----------------
  bit            m_on = 1'b0;
  bit            m_busy = 1'b0;
  int            m_age = 0;
  int            m_ptr = 0;
  int            m_id = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_ovf = 1'b0;
  int            m_wait [N];
  int            m_win;

  always_comb m_win = pick(bus.req_valid, m_ptr);

  always @(posedge clk) begin
    m_on <= m_on | rst;
    if (rst) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      m_age  <= 0;
      for (int i = 0; i < N; i++) m_wait[i] <= 0;
    end else if (m_busy) begin
      if (m_age >= 2 && bus.rsp_ready) m_busy <= 1'b0;
      else if (m_age < 2) m_age <= m_age + 1;
    end else if (m_win >= 0) begin
      m_busy <= 1'b1;
      m_age  <= 1;
      m_ptr  <= (m_win + 1) % N;
      m_id   <= m_win;
      m_data <= DW'(wide_sum(bus.req_a[m_win*DW +: DW], bus.req_b[m_win*DW +: DW]));
      m_ovf  <= (wide_sum(bus.req_a[m_win*DW +: DW], bus.req_b[m_win*DW +: DW]) > SMAX) ||
                (wide_sum(bus.req_a[m_win*DW +: DW], bus.req_b[m_win*DW +: DW]) < SMIN);
      if (m_on) chk("starvation_bound", m_wait[m_win] <= N - 1, 1);
      for (int i = 0; i < N; i++)
        m_wait[i] <= (i == m_win) ? 0 : (bus.req_valid[i] ? m_wait[i] + 1 : 0);
    end
  end

  // Compare process: DUT outputs against the model on every cycle after reset.
  always @(negedge clk) begin
    if (m_on) begin
      chk("m_req_ready", bus.req_ready, (rst || m_busy) ? '0 : onehot(m_win));
      chk("m_busy", bus.busy, m_busy);
      chk("m_rsp_valid", bus.rsp_valid, m_busy && m_age >= 2);
      if (m_busy && m_age >= 2) begin
        chk("m_rsp_data", bus.rsp_data, m_data);
        chk("m_rsp_id", bus.rsp_id, m_id);
        chk("m_rsp_ovf", bus.rsp_ovf, m_ovf);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic single_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] ed, input bit eo);
    set_op(i, a, b);
    bus.req_valid = onehot(i);
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("single_grant", bus.req_ready, onehot(i));
    step(); bus.req_valid = '0;
    @(negedge clk); chk("single_add_busy", bus.busy, 1); chk("single_add_novalid", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("single_rsp_valid", bus.rsp_valid, 1);
    chk("single_rsp_data", bus.rsp_data, ed);
    chk("single_rsp_id", bus.rsp_id, i);
    chk("single_rsp_ovf", bus.rsp_ovf, eo);
    step();
  endtask

  function automatic logic [DW-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int order[$];
    int when[$];
    logic [N-1:0] gnt;
    logic [DW-1:0] held;

    rst = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) begin @(negedge clk); chk("reset_gates_ready", bus.req_ready, 0); end
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_ovf", bus.rsp_ovf, 0);
    step();

    // single request and overflow/wrap corners
    single_op(0, 32'd5, 32'hFFFF_FFFD, 32'd2, 1'b0);
    single_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    single_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    single_op(3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);

    // round-robin with everyone valid
    apply_reset();
    for (int i = 0; i < N; i++) set_op(i, 32'(i * 10), 32'(i));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        order.push_back($clog2(bus.req_ready));
        when.push_back(c);
      end
      step();
    end
    bus.req_valid = '0;
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", (k < order.size()) ? order[k] : -1, k % 4);
      if (k > 0) chk("rr_spacing", (k < when.size()) ? when[k] - when[k-1] : -1, 3);
    end

    // backpressure while requesters 1 and 2 wait
    apply_reset();
    set_op(1, 32'd100, 32'd23);
    set_op(2, 32'hFFFF_FFF9, 32'd7);
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    @(negedge clk); chk("bp_grant", bus.req_ready, 4'b0010);
    step(); step();
    held = bus.rsp_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_data", bus.rsp_data, 32'd123);
      chk("bp_rsp_stable", bus.rsp_data, held);
      chk("bp_rsp_id", bus.rsp_id, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("bp_handshake_valid", bus.rsp_valid, 1);
    step();
    @(negedge clk); chk("bp_next_grant", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0;
    repeat (3) step();

    // pointer fairness
    apply_reset();
    set_op(1, 32'd1, 32'd1);
    set_op(3, 32'd3, 32'd3);
    bus.req_valid = 4'b1000;
    @(negedge clk); chk("pf_grant3", bus.req_ready, 4'b1000);
    step(); bus.req_valid = '0;
    step(); step();
    bus.req_valid = 4'b1010;
    @(negedge clk); chk("pf_first", bus.req_ready, 4'b0010);
    step(); bus.req_valid = 4'b1000;
    step(); step();
    @(negedge clk); chk("pf_second", bus.req_ready, 4'b1000);
    step(); bus.req_valid = '0;
    repeat (3) step();

    // reset while in ADD
    apply_reset();
    set_op(1, 32'd50, 32'd50);
    bus.req_valid = 4'b0010;
    @(negedge clk); chk("rm_grant1", bus.req_ready, 4'b0010);
    step(); bus.req_valid = '0; rst = 1'b1;
    @(negedge clk); chk("rm_busy_in_add", bus.busy, 1); chk("rm_ready_in_rst", bus.req_ready, 0);
    step(); rst = 1'b0;
    set_op(0, 32'd11, 32'd22);
    set_op(2, 32'd5, 32'd6);
    bus.req_valid = 4'b0101;
    @(negedge clk);
    chk("rm_no_rsp", bus.rsp_valid, 0);
    chk("rm_idle", bus.busy, 0);
    chk("rm_grant0", bus.req_ready, 4'b0001);
    step(); bus.req_valid = 4'b0100;
    @(negedge clk); chk("rm_no_rsp_add", bus.rsp_valid, 0);
    step();
    @(negedge clk);
    chk("rm_rsp_id", bus.rsp_id, 0);
    chk("rm_rsp_data", bus.rsp_data, 32'd33);
    step();
    @(negedge clk); chk("rm_grant2", bus.req_ready, 4'b0100);
    step(); bus.req_valid = '0;
    repeat (3) step();

    // randomized traffic with backpressure and occasional reset
    gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i] || !bus.req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.req_valid[i] = 1'b1;
            set_op(i, rand_op(), rand_op());
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      gnt = bus.req_ready;
      step();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
